// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and parameter legality.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package pipelined_adder_pkg;

  // Bits handled by each pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return (stages >= 1) ? width / stages : width;
  endfunction

  // Legal configurations: at least one stage, and an equal chunk per stage.
  function automatic bit params_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit adder slice with carry-in and carry-out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline registers its outputs.
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  // Full add of one slice; the extra top bit becomes the slice carry.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-chunk adder: sum = a + b + cin, one CHUNK-bit slice per stage.
// Latency: STAGES cycles from accept to out_valid, plus one per stall cycle.
// Backpressure: global stall; every stage holds while out_valid && !out_ready, in_ready = !stall.
// Optional PIPELINED_ADDER_OVF_EN adds a registered signed-overflow output (ovf).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  // Operand-B registers exist only between stages (none after the last one).
  localparam int BQ    = (STAGES > 1) ? STAGES - 1 : 1;

  if (!params_legal(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_adder: need STAGES >= 1, WIDTH >= 1 and WIDTH divisible by STAGES");
  end

  // The accumulator word rotates right by CHUNK each stage: the next operand-A
  // slice is always at the bottom and finished sum slices enter at the top, so
  // after STAGES rotations it holds the complete sum in natural bit order.
  // Operand B simply shifts right so its next slice is also at the bottom.
  logic             en;
  logic             v_q    [STAGES];
  logic             c_q    [STAGES];
  logic [WIDTH-1:0] acc_q  [STAGES];
  logic [WIDTH-1:0] b_q    [BQ];

  logic             v_in   [STAGES];
  logic             c_in   [STAGES];
  logic [WIDTH-1:0] acc_in [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [CHUNK-1:0] s_chunk  [STAGES];
  logic             co_chunk [STAGES];

  assign en        = !(out_valid && !out_ready);
  assign in_ready  = en;
  assign out_valid = v_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_in[k]   = in_valid;
      assign c_in[k]   = cin;
      assign acc_in[k] = a;
      assign b_in[k]   = b;
    end else begin : g_link
      assign v_in[k]   = v_q[k-1];
      assign c_in[k]   = c_q[k-1];
      assign acc_in[k] = acc_q[k-1];
      assign b_in[k]   = b_q[k-1];
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a  (acc_in[k][CHUNK-1:0]),
      .b  (b_in[k][CHUNK-1:0]),
      .ci (c_in[k]),
      .s  (s_chunk[k]),
      .co (co_chunk[k])
    );

    // Stage register: valid, slice carry and rotated accumulator advance together.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        acc_q[k] <= '0;
      end else if (en) begin
        v_q[k]   <= v_in[k];
        c_q[k]   <= co_chunk[k];
        acc_q[k] <= (acc_in[k] >> CHUNK) | (WIDTH'(s_chunk[k]) << (WIDTH - CHUNK));
      end
    end

    if (k < STAGES - 1) begin : g_bfwd
      // Forward the not-yet-consumed upper slices of operand B.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q[k] <= '0;
        end else if (en) begin
          b_q[k] <= b_in[k] >> CHUNK;
        end
      end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;
      // Operand MSBs reach the last stage inside the operand words; overflow
      // is judged there and registered alongside the top sum slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= (acc_in[k][CHUNK-1] == b_in[k][CHUNK-1]) &&
                   (s_chunk[k][CHUNK-1] != acc_in[k][CHUNK-1]);
        end
      end
      assign ovf = ovf_q;
    end
`endif
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
// Latency: n/a (testbench).
// Backpressure: drives out_ready patterns, checks stalls against a queue model.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;
`endif

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef PIPELINED_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic        held_vld = 1'b0;
  logic [15:0] held_sum;
  logic        held_cout;
  logic        seen_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow as an out-of-range result.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t        e;
    int unsigned t;
    int          s;
    t = 32'(x) + 32'(y) + 32'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    e.sum  = t[15:0];
    e.cout = (t >= 32'd65536);
    e.ovf  = (s > 32767) || (s < -32768);
    return e;
  endfunction

  // One clock: observe handshakes at the falling edge, then advance past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    seen_ov = out_valid;
    if (!rst_n) begin
      sb.delete();
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_sum", 32'(sum), 32'(held_sum));
        chk("stall_hold_cout", 32'(cout), 32'(held_cout));
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, cin));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got sum 0x%0h with no beat outstanding, expected none", sum);
        end else begin
          e = sb.pop_front();
          chk("sb_sum", 32'(sum), 32'(e.sum));
          chk("sb_cout", 32'(cout), 32'(e.cout));
`ifdef PIPELINED_ADDER_OVF_EN
          chk("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
      held_vld  = out_valid && !out_ready;
      held_sum  = sum;
      held_cout = cout;
    end
    @(posedge clk);
    #1;
  endtask

  // Advance until out_valid is seen, bounded; n counts clocks after the accepting edge.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Send a single beat with the pipeline otherwise empty and check latency and result.
  task automatic single_beat(input vec_t v);
    int n;
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("latency", 32'(n), 32'(STAGES - 1));
    chk("vec_sum", 32'(sum), 32'(v.sum));
    chk("vec_cout", 32'(cout), 32'(v.cout));
`ifdef PIPELINED_ADDER_OVF_EN
    chk("vec_ovf", 32'(ovf), 32'(v.ovf));
`endif
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    int   n, cnt, first, last;

    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[4] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
    tbl[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[9] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};

    // Reset held with input offered: nothing moves, outputs are zero, ready stays high.
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Directed single beats, the first being the first accept after reset.
    for (int i = 0; i < 10; i++) single_beat(tbl[i]);

    // Back-to-back streaming with the consumer always ready.
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        in_valid = 1'b1; a = 16'(i); b = 16'(16'h8000 + i); cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (seen_ov) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_count", 32'(cnt), 32'd8);
    chk("stream_contiguous", 32'(last - first + 1), 32'd8);
    chk("stream_first_cycle", 32'(first), 32'(STAGES));

    // Fill the pipe against a stalled consumer, hold, then swap one out / one in.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 16'(16'h1000 + i); b = 16'(16'h0100 * i); cin = 1'(i & 1);
      tick();
    end
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_swap_inflight", 32'(sb.size()), 32'd4);
    chk("bp_no_bubble", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    repeat (8) tick();
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Reset with three beats in flight: none may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'(16'h0300 + i); b = 16'h0003; cin = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (seen_ov) cnt++;
    end
    chk("midrst_no_output", 32'(cnt), 32'd0);
    single_beat('{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0});

    // Random traffic with random backpressure against the queue model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("rand_drained", 32'(sb.size()), 32'd0);
    chk("rand_idle", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
